// File: rtl/smart_home.sv
// Smart-home controller: air-conditioning control plus a button-driven RGB colour counter.
// Define SMART_HOME_HYST_EN for the 3-state hysteresis AC; otherwise the AC is two registered comparators.
module smart_home (
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  input  logic [4:0] temperature,
  output logic       heating,
  output logic       cooling,
  output logic [2:0] colour
);

  localparam logic [4:0] HEAT_ON_MAX  = 5'd18;
  localparam logic [4:0] MID_POINT    = 5'd20;
  localparam logic [4:0] COOL_ON_MIN  = 5'd22;

  logic       heating_q, heating_d;
  logic       cooling_q, cooling_d;
  logic [2:0] colour_q, colour_d;

`ifdef SMART_HOME_HYST_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAT = 2'd1,
    COOL = 2'd2
  } ac_state_e;

  ac_state_e state_q, state_d;

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: begin
        if (temperature <= HEAT_ON_MAX)      state_d = HEAT;
        else if (temperature >= COOL_ON_MIN) state_d = COOL;
        else                                 state_d = IDLE;
      end
      HEAT:    state_d = (temperature >= MID_POINT) ? IDLE : HEAT;
      COOL:    state_d = (temperature <= MID_POINT) ? IDLE : COOL;
      default: state_d = IDLE;
    endcase
    // Outputs are registered alongside the state so they always match it.
    heating_d = (state_d == HEAT);
    cooling_d = (state_d == COOL);
  end
`else
  always_comb begin
    heating_d = (temperature <= HEAT_ON_MAX);
    cooling_d = (temperature >= COOL_ON_MIN);
  end
`endif

  // Out-of-range codes recover to 1 regardless of the button.
  always_comb begin
    colour_d = colour_q;
    if (colour_q == 3'd0 || colour_q == 3'd7) begin
      colour_d = 3'd1;
    end else if (button) begin
      colour_d = (colour_q == 3'd6) ? 3'd1 : colour_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef SMART_HOME_HYST_EN
      state_q   <= IDLE;
`endif
      heating_q <= 1'b0;
      cooling_q <= 1'b0;
      colour_q  <= 3'd0;
    end else begin
`ifdef SMART_HOME_HYST_EN
      state_q   <= state_d;
`endif
      heating_q <= heating_d;
      cooling_q <= cooling_d;
      colour_q  <= colour_d;
    end
  end

  assign heating = heating_q;
  assign cooling = cooling_q;
  assign colour  = colour_q;

endmodule

// File: tb/tb_smart_home.sv
// Directed testbench for smart_home; covers the build selected by SMART_HOME_HYST_EN.
module tb_smart_home;

  logic       clk;
  logic       rst;
  logic       button;
  logic [4:0] temperature;
  logic       heating;
  logic       cooling;
  logic [2:0] colour;

  int checks_cnt;
  int fail_cnt;

  smart_home dut (
    .clk         (clk),
    .rst         (rst),
    .button      (button),
    .temperature (temperature),
    .heating     (heating),
    .cooling     (cooling),
    .colour      (colour)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int col_seq[12];
    int hold_seq[8];
    col_seq  = '{2, 2, 3, 3, 4, 4, 5, 5, 6, 6, 1, 1};
    hold_seq = '{5, 6, 1, 2, 3, 4, 5, 6};
    checks_cnt  = 0;
    fail_cnt    = 0;
    rst         = 1'b0;
    button      = 1'b1;
    temperature = 5'd15;

    // Asynchronous reset takes effect between edges.
    #2 rst = 1'b1;
    #1;
    check_eq("rst_heating", heating, 0);
    check_eq("rst_cooling", cooling, 0);
    check_eq("rst_colour", colour, 0);
    step();
    check_eq("rst_hold_colour", colour, 0);
    check_eq("rst_hold_heating", heating, 0);

    rst = 1'b0;
    step();
    check_eq("rel_colour", colour, 1);
    check_eq("rel_heating", heating, 1);
    check_eq("rel_cooling", cooling, 0);

    // Pulsed button: one cycle high, one cycle low.
    for (int i = 0; i < 12; i++) begin
      button = (i % 2 == 0) ? 1'b1 : 1'b0;
      step();
      check_eq($sformatf("pulse_colour[%0d]", i), colour, col_seq[i]);
    end

    button = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("to4_colour[%0d]", i), colour, i + 2);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq($sformatf("hold_colour[%0d]", i), colour, hold_seq[i]);
    end
    button = 1'b0;
    step();
    check_eq("idle_colour", colour, 6);

`ifdef SMART_HOME_HYST_EN
    // Restart the AC from IDLE with an in-band temperature.
    temperature = 5'd20;
    rst = 1'b1;
    #1;
    check_eq("midrst_heating", heating, 0);
    check_eq("midrst_colour", colour, 0);
    rst = 1'b0;
    step();
    check_eq("idle_heating", heating, 0);
    check_eq("idle_cooling", cooling, 0);

    for (int t = 15; t <= 31; t++) begin
      temperature = 5'(t);
      step();
      check_eq($sformatf("up_heating[t=%0d]", t), heating, (t <= 19) ? 1 : 0);
      check_eq($sformatf("up_cooling[t=%0d]", t), cooling, (t >= 22) ? 1 : 0);
      check_eq($sformatf("up_excl[t=%0d]", t), heating & cooling, 0);
    end

    for (int t = 25; t >= 17; t--) begin
      temperature = 5'(t);
      step();
      check_eq($sformatf("dn_cooling[t=%0d]", t), cooling, (t >= 21) ? 1 : 0);
      check_eq($sformatf("dn_heating[t=%0d]", t), heating, (t <= 18) ? 1 : 0);
    end

    // Large jump from HEAT to hot goes through IDLE first.
    temperature = 5'd31;
    step();
    check_eq("jump1_heating", heating, 0);
    check_eq("jump1_cooling", cooling, 0);
    step();
    check_eq("jump2_cooling", cooling, 1);
`else
    begin
      int tv[7];
      int eh[7];
      int ec[7];
      tv = '{19, 20, 21, 18, 22, 31, 0};
      eh = '{0, 0, 0, 1, 0, 0, 1};
      ec = '{0, 0, 0, 0, 1, 1, 0};
      for (int i = 0; i < 7; i++) begin
        temperature = 5'(tv[i]);
        step();
        check_eq($sformatf("cmp_heating[t=%0d]", tv[i]), heating, eh[i]);
        check_eq($sformatf("cmp_cooling[t=%0d]", tv[i]), cooling, ec[i]);
      end
    end
    // No combinational path: output still shows the previous sample.
    @(negedge clk);
    temperature = 5'd25;
    #1;
    check_eq("lat_heating_before", heating, 1);
    check_eq("lat_cooling_before", cooling, 0);
    step();
    check_eq("lat_cooling_after", cooling, 1);

    rst = 1'b1;
    #1;
    check_eq("midrst_cooling", cooling, 0);
    check_eq("midrst_colour", colour, 0);
    rst = 1'b0;
    button = 1'b1;
    step();
    check_eq("rel2_colour", colour, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
